// File: rtl/mem_swap_ctrl.sv
// mem_swap_ctrl: swaps the contents of two register-file locations per start pulse.
// The sequence is read A, read B, write A, write B, then a one-cycle done pulse.
// Optional feature macro SWAP_COUNT_EN adds the swap_count port and its counter.
// Every output is decoded from registered state only; no input reaches an output
// combinationally.
module mem_swap_ctrl #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_r,
    output logic [ADDR_WIDTH-1:0] address_r,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] address_w,
    output logic [DATA_WIDTH-1:0] data_w,
    output logic                  busy,
    output logic                  done
`ifdef SWAP_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  swap_count
`endif
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        WR_A = 3'd3,
        WR_B = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
    logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
    logic [DATA_WIDTH-1:0] tmp_a_q, tmp_a_d;
    logic [DATA_WIDTH-1:0] tmp_b_q, tmp_b_d;

    // State register; reset returns straight to IDLE, which drops we at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; equal addresses skip all memory traffic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (addr_a != addr_b) ? RD_A : DONE;
            RD_A: state_d = RD_B;
            RD_B: state_d = WR_A;
            WR_A: state_d = WR_B;
            WR_B: state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from state and captured registers only.
    always_comb begin
        address_r = '0;
        we        = 1'b0;
        address_w = '0;
        data_w    = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            RD_A: begin
                address_r = addr_a_q;
                busy      = 1'b1;
            end
            RD_B: begin
                address_r = addr_b_q;
                busy      = 1'b1;
            end
            WR_A: begin
                we        = 1'b1;
                address_w = addr_a_q;
                data_w    = tmp_b_q;
                busy      = 1'b1;
            end
            WR_B: begin
                we        = 1'b1;
                address_w = addr_b_q;
                data_w    = tmp_a_q;
                busy      = 1'b1;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Capture addresses on acceptance and read data in the two read states.
    always_comb begin
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        tmp_a_d  = tmp_a_q;
        tmp_b_d  = tmp_b_q;
        if (state_q == IDLE && start) begin
            addr_a_d = addr_a;
            addr_b_d = addr_b;
        end
        if (state_q == RD_A) tmp_a_d = data_r;
        if (state_q == RD_B) tmp_b_d = data_r;
    end

    // Datapath registers; a reset mid-swap leaves memory as-is (no rollback).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_a_q <= '0;
            addr_b_q <= '0;
            tmp_a_q  <= '0;
            tmp_b_q  <= '0;
        end else begin
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            tmp_a_q  <= tmp_a_d;
            tmp_b_q  <= tmp_b_d;
        end
    end

`ifdef SWAP_COUNT_EN
    logic [CNT_WIDTH-1:0] swap_count_q, swap_count_d;

    // Completed-swap counter, bumped once per DONE cycle; wraps naturally.
    always_comb begin
        swap_count_d = swap_count_q;
        if (state_q == DONE) swap_count_d = swap_count_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) swap_count_q <= '0;
        else          swap_count_q <= swap_count_d;
    end

    assign swap_count = swap_count_q;
`else
    localparam int unused_cnt_width = CNT_WIDTH;
`endif

endmodule

// File: tb/tb_mem_swap_ctrl.sv
// Scoreboard bench for mem_swap_ctrl with a behavioural register file.
// Build with +define+SWAP_COUNT_EN to also check the wrapping 2-bit counter.
module tb_mem_swap_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [6:0] addr_a, addr_b;
    logic [7:0] data_r;
    logic [6:0] address_r, address_w;
    logic       we;
    logic [7:0] data_w;
    logic       busy, done;
`ifdef SWAP_COUNT_EN
    logic [1:0] swap_count;
`endif

    mem_swap_ctrl #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .CNT_WIDTH(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .addr_a(addr_a), .addr_b(addr_b), .data_r(data_r),
        .address_r(address_r), .we(we), .address_w(address_w),
        .data_w(data_w), .busy(busy), .done(done)
`ifdef SWAP_COUNT_EN
        , .swap_count(swap_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // register file: single write port, async read
    logic [7:0] mem [128];
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = i[7:0];
        mem[5]   = 8'hAA;
        mem[9]   = 8'h55;
        mem[12]  = 8'h3C;
        mem[0]   = 8'h11;
        mem[127] = 8'h77;
        forever begin
            @(posedge clk);
            if (we) mem[address_w] <= data_w;
        end
    end
    assign data_r = mem[address_r];

    typedef struct { int cyc; logic [6:0] a; logic [7:0] d; } wr_t;
    typedef struct { int cyc; logic [1:0] cnt; } dn_t;
    wr_t wq[$];
    dn_t dq[$];
    logic [1:0] cnt_model = 2'd0;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // expected traffic of one swap accepted at edge n
    task automatic exp_swap(input logic [6:0] a, input logic [6:0] b,
                            input logic [7:0] da, input logic [7:0] db, input int n);
        wr_t w;
        dn_t d;
        if (a != b) begin
            w.cyc = n + 2; w.a = a; w.d = da; wq.push_back(w);
            w.cyc = n + 3; w.a = b; w.d = db; wq.push_back(w);
            d.cyc = n + 4;
        end else begin
            d.cyc = n;
        end
        cnt_model = cnt_model + 2'd1;
        d.cnt = cnt_model;
        dq.push_back(d);
    endtask

    // monitor: pop and compare whenever the DUT writes or signals done
    wr_t mw;
    dn_t md;
    logic       cnt_pend = 1'b0;
    logic [1:0] cnt_exp  = 2'd0;
    always @(negedge clk) begin
        if (reset_n) begin
`ifdef SWAP_COUNT_EN
            if (cnt_pend) check("swap_count", {30'd0, swap_count}, {30'd0, cnt_exp});
`endif
            cnt_pend = 1'b0;
            if (we) begin
                if (wq.size() == 0) check("unexpected_we", 32'd1, 32'd0);
                else begin
                    mw = wq.pop_front();
                    check("wr_cycle", cyc, mw.cyc);
                    check("wr_addr", {25'd0, address_w}, {25'd0, mw.a});
                    check("wr_data", {24'd0, data_w}, {24'd0, mw.d});
                    check("busy_in_wr", {31'd0, busy}, 32'd1);
                end
            end
            if (done) begin
                if (dq.size() == 0) check("unexpected_done", 32'd1, 32'd0);
                else begin
                    md = dq.pop_front();
                    check("done_cycle", cyc, md.cyc);
                    check("busy_in_done", {31'd0, busy}, 32'd0);
                    cnt_exp  = md.cnt;
                    cnt_pend = 1'b1;
                end
            end
        end
    end

    int n;

    initial begin
        reset_n = 1'b0; start = 1'b0; addr_a = '0; addr_b = '0;
        repeat (2) @(negedge clk);
        check("reset_outs", {10'd0, busy, done, we, address_r, address_w, data_w},
              32'd0);
`ifdef SWAP_COUNT_EN
        check("reset_count", {30'd0, swap_count}, 32'd0);
`endif
        reset_n = 1'b1;
        @(negedge clk);

        // normal swap 5<->9
        n = cyc + 1; start = 1'b1; addr_a = 7'd5; addr_b = 7'd9;
        exp_swap(7'd5, 7'd9, 8'h55, 8'hAA, n);
        @(negedge clk); start = 1'b0;
        check("busy_rd_a", {31'd0, busy}, 32'd1);
        repeat (8) @(negedge clk);
        check("t1_mem5", {24'd0, mem[5]}, 32'h55);
        check("t1_mem9", {24'd0, mem[9]}, 32'hAA);
        check("t1_mem4", {24'd0, mem[4]}, 32'h04);
        check("t1_mem10", {24'd0, mem[10]}, 32'h0A);

        // equal addresses: done only, no writes
        n = cyc + 1; start = 1'b1; addr_a = 7'd12; addr_b = 7'd12;
        exp_swap(7'd12, 7'd12, 8'h00, 8'h00, n);
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        check("t2_mem12", {24'd0, mem[12]}, 32'h3C);

        // second start during RD_B is ignored; address changes are ignored too
        n = cyc + 1; start = 1'b1; addr_a = 7'd5; addr_b = 7'd9;
        exp_swap(7'd5, 7'd9, 8'hAA, 8'h55, n);
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; addr_a = 7'd1; addr_b = 7'd2;
        @(negedge clk); start = 1'b0;
        repeat (8) @(negedge clk);
        check("t3_mem1", {24'd0, mem[1]}, 32'h01);
        check("t3_mem2", {24'd0, mem[2]}, 32'h02);
        check("t3_mem5", {24'd0, mem[5]}, 32'hAA);
        check("t3_mem9", {24'd0, mem[9]}, 32'h55);

        // reset landing in WR_B: only the A write happens
        n = cyc + 1; start = 1'b1; addr_a = 7'd5; addr_b = 7'd9;
        begin
            wr_t w;
            w.cyc = n + 2; w.a = 7'd5; w.d = 8'h55; wq.push_back(w);
        end
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_we", {31'd0, we}, 32'd0);
        check("rst_async_busy", {31'd0, busy}, 32'd0);
        cnt_model = 2'd0;
        @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        check("rst_idle_outs", {17'd0, busy, done, address_r, address_w}, 32'd0);
        check("t4_mem5", {24'd0, mem[5]}, 32'h55);
        check("t4_mem9", {24'd0, mem[9]}, 32'h55);
        @(negedge clk);

        // start held high: three back-to-back swaps of 0<->127
        n = cyc + 1; start = 1'b1; addr_a = 7'd0; addr_b = 7'd127;
        exp_swap(7'd0, 7'd127, 8'h77, 8'h11, n);
        exp_swap(7'd0, 7'd127, 8'h11, 8'h77, n + 6);
        exp_swap(7'd0, 7'd127, 8'h77, 8'h11, n + 12);
        repeat (13) @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("t5_mem0", {24'd0, mem[0]}, 32'h77);
        check("t5_mem127", {24'd0, mem[127]}, 32'h11);

        // two more swaps to carry the count through its wrap
        n = cyc + 1; start = 1'b1; addr_a = 7'd5; addr_b = 7'd9;
        exp_swap(7'd5, 7'd9, 8'h55, 8'h55, n);
        @(negedge clk); start = 1'b0;
        repeat (8) @(negedge clk);
        n = cyc + 1; start = 1'b1; addr_a = 7'd12; addr_b = 7'd12;
        exp_swap(7'd12, 7'd12, 8'h00, 8'h00, n);
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);

        check("wq_drained", wq.size(), 32'd0);
        check("dq_drained", dq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
